// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, 32-step iterative multiply/divide unit and the EX/MEM
// pipeline register feeding mem_stage.
module ex_stage #(
  parameter int          DATA_W  = 32,
  parameter int          ADDR_W  = 30,
  parameter int          MD_CYC  = 32,
  parameter logic [2:0]  EXP_OVF = 3'h2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              IDEn,
  input  logic [ADDR_W-1:0] IDPC,
  input  logic [3:0]        IDALUOp,
  input  logic [DATA_W-1:0] IDALUIn0,
  input  logic [DATA_W-1:0] IDALUIn1,
  input  logic              IDBrFlag,
  input  logic [1:0]        IDMemOp,
  input  logic [DATA_W-1:0] IDMemWrData,
  input  logic [1:0]        IDCtrlOp,
  input  logic [4:0]        IDDstAddr,
  input  logic              IDGPRWE_,
  input  logic [2:0]        IDExpCode,
  output logic [DATA_W-1:0] EXFwdData,
  output logic              Busy,
  output logic              EXEn,
  output logic [ADDR_W-1:0] EXPC,
  output logic              EXBrFlag,
  output logic [1:0]        EXMemOp,
  output logic [DATA_W-1:0] EXMemWrData,
  output logic [1:0]        EXCtrlOp,
  output logic [4:0]        EXDstAddr,
  output logic              EXGPRWE_,
  output logic [2:0]        EXExpCode,
  output logic [DATA_W-1:0] EXOut
);

  localparam int CNT_W = $clog2(MD_CYC);
  localparam int SH_W  = $clog2(DATA_W);

  localparam logic [3:0] OP_PASS = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_ADDS = 4'd4;
  localparam logic [3:0] OP_ADDU = 4'd5;
  localparam logic [3:0] OP_SUBS = 4'd6;
  localparam logic [3:0] OP_SUBU = 4'd7;
  localparam logic [3:0] OP_SHRL = 4'd8;
  localparam logic [3:0] OP_SHLL = 4'd9;
  localparam logic [3:0] OP_MULU = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_REMU = 4'd12;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic              busy_int;
  logic              is_md;
  logic [DATA_W-1:0] alu_res;
  logic              ovf;
  logic [DATA_W-1:0] sum, diff;
  logic [DATA_W-1:0] result;

  logic [3:0]        md_op;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] md_a;    // multiplicand (shifted left) or divisor
  logic [DATA_W-1:0] md_b;    // multiplier (shifted right) or dividend/quotient
  logic [DATA_W-1:0] md_acc;  // product accumulator or partial remainder
  logic [DATA_W-1:0] md_res;
  logic [DATA_W:0]   rem_sh;
  logic              rem_ge;

  // ALU
  always_comb begin
    alu_res = '0;
    ovf     = 1'b0;
    sum     = IDALUIn0 + IDALUIn1;
    diff    = IDALUIn0 - IDALUIn1;
    case (IDALUOp)
      OP_PASS: alu_res = IDALUIn0;
      OP_AND:  alu_res = IDALUIn0 & IDALUIn1;
      OP_OR:   alu_res = IDALUIn0 | IDALUIn1;
      OP_XOR:  alu_res = IDALUIn0 ^ IDALUIn1;
      OP_ADDS: begin
        alu_res = sum;
        ovf     = (IDALUIn0[DATA_W-1] == IDALUIn1[DATA_W-1]) &&
                  (sum[DATA_W-1] != IDALUIn0[DATA_W-1]);
      end
      OP_ADDU: alu_res = sum;
      OP_SUBS: begin
        alu_res = diff;
        ovf     = (IDALUIn0[DATA_W-1] != IDALUIn1[DATA_W-1]) &&
                  (diff[DATA_W-1] != IDALUIn0[DATA_W-1]);
      end
      OP_SUBU: alu_res = diff;
      OP_SHRL: alu_res = IDALUIn0 >> IDALUIn1[SH_W-1:0];
      OP_SHLL: alu_res = IDALUIn0 << IDALUIn1[SH_W-1:0];
      default: alu_res = '0;
    endcase
  end

  assign is_md = IDEn && ((IDALUOp == OP_MULU) || (IDALUOp == OP_DIVU) ||
                          (IDALUOp == OP_REMU));

  // Mul/div FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_int  = 1'b0;
    case (state)
      S_IDLE: begin
        if (is_md) begin
          busy_int  = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy_int = 1'b1;
        if (cnt == '0) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (!Stall) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (Flush) state_nxt = S_IDLE;
  end

  // Reset must drop Busy at once even while a mul/div op still sits on the ID inputs.
  assign Busy = busy_int && !reset;

  // Restoring division step: shift next dividend bit into the partial remainder.
  assign rem_sh = {md_acc, md_b[DATA_W-1]};
  assign rem_ge = rem_sh >= {1'b0, md_a};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_op  <= OP_PASS;
      cnt    <= '0;
      md_a   <= '0;
      md_b   <= '0;
      md_acc <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_md) begin
            md_op  <= IDALUOp;
            cnt    <= CNT_W'(MD_CYC - 1);
            md_acc <= '0;
            if (IDALUOp == OP_MULU) begin
              md_a <= IDALUIn0;
              md_b <= IDALUIn1;
            end else begin
              md_a <= IDALUIn1;
              md_b <= IDALUIn0;
            end
          end
        end
        S_RUN: begin
          cnt <= cnt - 1'b1;
          if (md_op == OP_MULU) begin
            if (md_b[0]) md_acc <= md_acc + md_a;
            md_a <= md_a << 1;
            md_b <= md_b >> 1;
          end else begin
            md_b <= {md_b[DATA_W-2:0], rem_ge};
            if (rem_ge) md_acc <= rem_sh[DATA_W-1:0] - md_a;
            else        md_acc <= rem_sh[DATA_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (md_op)
      OP_MULU: md_res = md_acc;
      OP_DIVU: md_res = md_b;
      OP_REMU: md_res = md_acc;
      default: md_res = '0;
    endcase
  end

  assign result    = (state == S_DONE) ? md_res : alu_res;
  assign EXFwdData = result;

  // EX/MEM register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      EXEn        <= 1'b0;
      EXPC        <= '0;
      EXBrFlag    <= 1'b0;
      EXMemOp     <= '0;
      EXMemWrData <= '0;
      EXCtrlOp    <= '0;
      EXDstAddr   <= '0;
      EXGPRWE_    <= 1'b1;
      EXExpCode   <= '0;
      EXOut       <= '0;
    end else if (Flush) begin
      EXEn        <= 1'b0;
      EXPC        <= '0;
      EXBrFlag    <= 1'b0;
      EXMemOp     <= '0;
      EXMemWrData <= '0;
      EXCtrlOp    <= '0;
      EXDstAddr   <= '0;
      EXGPRWE_    <= 1'b1;
      EXExpCode   <= '0;
      EXOut       <= '0;
    end else if (!Stall && !busy_int) begin
      EXEn        <= IDEn;
      EXPC        <= IDPC;
      EXBrFlag    <= IDBrFlag;
      EXMemWrData <= IDMemWrData;
      EXDstAddr   <= IDDstAddr;
      EXOut       <= result;
      EXCtrlOp    <= IDEn ? IDCtrlOp : 2'd0;
      if (!IDEn) begin
        EXGPRWE_  <= 1'b1;
        EXMemOp   <= '0;
        EXExpCode <= IDExpCode;
      end else if (IDExpCode != 3'd0) begin
        EXGPRWE_  <= IDGPRWE_;
        EXMemOp   <= IDMemOp;
        EXExpCode <= IDExpCode;
      end else if (ovf && (state != S_DONE)) begin
        EXGPRWE_  <= 1'b1;
        EXMemOp   <= '0;
        EXExpCode <= EXP_OVF;
      end else begin
        EXGPRWE_  <= IDGPRWE_;
        EXMemOp   <= IDMemOp;
        EXExpCode <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU vector table, mul/div table, and hand sequences for
// stall-in-DONE, flush mid-RUN and reset mid-RUN.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        id_en;
  logic [29:0] id_pc;
  logic [3:0]  id_op;
  logic [31:0] id_in0, id_in1;
  logic        id_br;
  logic [1:0]  id_mem;
  logic [31:0] id_wd;
  logic [1:0]  id_ctrl;
  logic [4:0]  id_dst;
  logic        id_we_n;
  logic [2:0]  id_exp;
  logic [31:0] fwd;
  logic        busy;
  logic        ex_en;
  logic [29:0] ex_pc;
  logic        ex_br;
  logic [1:0]  ex_mem;
  logic [31:0] ex_wd;
  logic [1:0]  ex_ctrl;
  logic [4:0]  ex_dst;
  logic        ex_we_n;
  logic [2:0]  ex_exp;
  logic [31:0] ex_out;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .reset(reset), .Stall(stall), .Flush(flush),
    .IDEn(id_en), .IDPC(id_pc), .IDALUOp(id_op), .IDALUIn0(id_in0), .IDALUIn1(id_in1),
    .IDBrFlag(id_br), .IDMemOp(id_mem), .IDMemWrData(id_wd), .IDCtrlOp(id_ctrl),
    .IDDstAddr(id_dst), .IDGPRWE_(id_we_n), .IDExpCode(id_exp),
    .EXFwdData(fwd), .Busy(busy),
    .EXEn(ex_en), .EXPC(ex_pc), .EXBrFlag(ex_br), .EXMemOp(ex_mem), .EXMemWrData(ex_wd),
    .EXCtrlOp(ex_ctrl), .EXDstAddr(ex_dst), .EXGPRWE_(ex_we_n), .EXExpCode(ex_exp),
    .EXOut(ex_out)
  );

  localparam logic [3:0] PASS = 4'd0, AND_ = 4'd1, OR_ = 4'd2, XOR_ = 4'd3, ADDS = 4'd4,
                         ADDU = 4'd5, SUBS = 4'd6, SUBU = 4'd7, SHRL = 4'd8, SHLL = 4'd9,
                         MULU = 4'd10, DIVU = 4'd11, REMU = 4'd12;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        en;
    logic [1:0]  mem, ctrl;
    logic        we_n;
    logic [2:0]  expin;
    logic [31:0] q;
    logic [2:0]  qexp;
    logic        qwe_n;
    logic [1:0]  qmem, qctrl;
    logic        qen;
  } alu_vec_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, q;
  } md_vec_t;

  alu_vec_t av[13];
  md_vec_t  mv[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_id(input logic en, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] mem, input logic [1:0] ctrl,
                        input logic we_n, input logic [2:0] expin);
    id_en = en; id_op = op; id_in0 = a; id_in1 = b;
    id_mem = mem; id_ctrl = ctrl; id_we_n = we_n; id_exp = expin;
  endtask

  task automatic wait_idle_done(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      step();
    end
  endtask

  initial begin
    int cyc;
    //         op    a             b             en mem ctrl we expin q             qexp qwe qmem qctrl qen
    av[0]  = '{ADDU, 32'hFFFFFFFF, 32'h1,        1, 1, 0, 0, 0, 32'h0,        0, 0, 1, 0, 1};
    av[1]  = '{ADDS, 32'h7FFFFFFF, 32'h1,        1, 2, 1, 0, 0, 32'h80000000, 2, 1, 0, 1, 1};
    av[2]  = '{SUBS, 32'h80000000, 32'h1,        1, 1, 0, 0, 0, 32'h7FFFFFFF, 2, 1, 0, 0, 1};
    av[3]  = '{SUBU, 32'h0,        32'h1,        1, 1, 0, 0, 0, 32'hFFFFFFFF, 0, 0, 1, 0, 1};
    av[4]  = '{AND_, 32'hF0F0F0F0, 32'hFF00FF00, 1, 1, 0, 0, 0, 32'hF000F000, 0, 0, 1, 0, 1};
    av[5]  = '{OR_,  32'h0F0F0000, 32'h000000F0, 1, 1, 0, 0, 0, 32'h0F0F00F0, 0, 0, 1, 0, 1};
    av[6]  = '{XOR_, 32'hFFFF0000, 32'h0F0F0F0F, 1, 1, 0, 0, 0, 32'hF0F00F0F, 0, 0, 1, 0, 1};
    av[7]  = '{SHRL, 32'h80000000, 32'h3F,       1, 1, 0, 0, 0, 32'h1,        0, 0, 1, 0, 1};
    av[8]  = '{SHLL, 32'h1,        32'h24,       1, 1, 0, 0, 0, 32'h10,       0, 0, 1, 0, 1};
    av[9]  = '{PASS, 32'h12345678, 32'h9,        1, 3, 2, 0, 0, 32'h12345678, 0, 0, 3, 2, 1};
    av[10] = '{ADDS, 32'h7FFFFFFF, 32'h1,        1, 1, 0, 0, 5, 32'h80000000, 5, 0, 1, 0, 1};
    av[11] = '{ADDU, 32'h3,        32'h4,        0, 2, 1, 0, 0, 32'h7,        0, 1, 0, 0, 0};
    av[12] = '{ADDS, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 0, 0, 0, 32'hFFFFFFFE, 0, 0, 1, 0, 1};

    mv[0] = '{MULU, 32'd1234,      32'd5678,      32'd7006652};
    mv[1] = '{MULU, 32'h10000,     32'h10000,     32'h0};
    mv[2] = '{MULU, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h1};
    mv[3] = '{DIVU, 32'd100,       32'd7,         32'd14};
    mv[4] = '{REMU, 32'd100,       32'd7,         32'd2};
    mv[5] = '{DIVU, 32'd12345,     32'd0,         32'hFFFFFFFF};
    mv[6] = '{REMU, 32'd5,         32'd0,         32'd5};

    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    id_pc = '0; id_br = 1'b0; id_wd = '0; id_dst = '0;
    set_id(0, PASS, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_exen", ex_en, 0);
    chk("rst_exout", ex_out, 0);
    chk("rst_gprwe", ex_we_n, 1);
    chk("rst_expc", ex_pc, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 13; i++) begin
      set_id(av[i].en, av[i].op, av[i].a, av[i].b, av[i].mem, av[i].ctrl, av[i].we_n,
             av[i].expin);
      id_pc  = 30'(i + 100);
      id_dst = 5'(i + 1);
      #1;
      chk($sformatf("alu%0d_fwd", i), fwd, av[i].q);
      step();
      chk($sformatf("alu%0d_out", i), ex_out, av[i].q);
      chk($sformatf("alu%0d_exp", i), ex_exp, av[i].qexp);
      chk($sformatf("alu%0d_gprwe", i), ex_we_n, av[i].qwe_n);
      chk($sformatf("alu%0d_memop", i), ex_mem, av[i].qmem);
      chk($sformatf("alu%0d_ctrl", i), ex_ctrl, av[i].qctrl);
      chk($sformatf("alu%0d_en", i), ex_en, av[i].qen);
      chk($sformatf("alu%0d_pc", i), ex_pc, 30'(i + 100));
      chk($sformatf("alu%0d_dst", i), ex_dst, 5'(i + 1));
    end

    for (int i = 0; i < 7; i++) begin
      set_id(1, mv[i].op, mv[i].a, mv[i].b, 0, 0, 0, 0);
      #1;
      chk($sformatf("md%0d_busy0", i), busy, 1);
      wait_idle_done(cyc);
      chk($sformatf("md%0d_busycyc", i), cyc, 33);
      chk($sformatf("md%0d_fwd", i), fwd, mv[i].q);
      step();
      chk($sformatf("md%0d_out", i), ex_out, mv[i].q);
      chk($sformatf("md%0d_en", i), ex_en, 1);
      set_id(0, PASS, 0, 0, 0, 0, 1, 0);
      step();
    end

    // Stall held in DONE: register keeps the previous result until release.
    set_id(1, ADDU, 32'd10, 32'd20, 0, 0, 0, 0);
    step();
    chk("stl_pre", ex_out, 32'd30);
    set_id(1, MULU, 32'd6, 32'd7, 0, 0, 0, 0);
    step();
    wait_idle_done(cyc);
    chk("stl_busycyc", cyc, 32);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("stl%0d_hold", k), ex_out, 32'd30);
      chk($sformatf("stl%0d_busy", k), busy, 0);
      chk($sformatf("stl%0d_fwd", k), fwd, 32'd42);
    end
    stall = 1'b0;
    step();
    chk("stl_release", ex_out, 32'd42);
    set_id(0, PASS, 0, 0, 0, 0, 1, 0);
    step();

    // Flush at RUN cycle 10.
    set_id(1, MULU, 32'd3, 32'd3, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) step();
    flush = 1'b1;
    #1;
    chk("fl_busy_before", busy, 1);
    step();
    flush = 1'b0;
    set_id(1, ADDU, 32'd3, 32'd4, 0, 0, 0, 0);
    #1;
    chk("fl_busy_after", busy, 0);
    chk("fl_exen", ex_en, 0);
    chk("fl_exout", ex_out, 0);
    step();
    chk("fl_add_out", ex_out, 32'd7);
    chk("fl_add_en", ex_en, 1);

    // Asynchronous reset in the middle of a divide.
    set_id(1, DIVU, 32'd100, 32'd7, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) step();
    chk("rr_busy_run", busy, 1);
    reset = 1'b1;
    #1;
    chk("rr_busy", busy, 0);
    chk("rr_exen", ex_en, 0);
    chk("rr_exout", ex_out, 0);
    chk("rr_gprwe", ex_we_n, 1);
    step();
    set_id(1, ADDU, 32'd1, 32'd1, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    chk("rr_idle", busy, 0);
    step();
    chk("rr_add_out", ex_out, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
